topk_drain: RTL and testbench
=============================

// Module: topk_drain
// PURPOSE
//  Drains the sorted vector of a bitonic sorter (bitonic_32 data_32 lane or smaller) and streams its top-K
//  elements one per handshake on a valid/ready port. Sits after the sorter pipeline, which cannot stall, so the
//  block buffers whole vectors, flags lost ones and never backpressures its input.
//  Input order is descending: x_i[0] is the largest element, so top-K = x_i[0..K-1].
// PARAMETERS
//  DATAWIDTH   8   element width in bits
//  DATALENGTH  32  elements per sorted input vector
//  K           8   elements emitted per vector; legal range 1..DATALENGTH (elaboration error otherwise)
//  RANKW       $clog2(DATALENGTH) (min 1), width of rank output (localparam)
// PORTS
//  clk_i       in   1                        clock
//  rstn_i      in   1                        asynchronous reset, active low
//  in_valid_i  in   1                        x_i carries a sorted vector this cycle (sorter ctrl_o valid bit)
//  x_i         in   DATAWIDTH x [DATALENGTH] sorted vector, descending
//  clr_ovf_i   in   1                        clear sticky overflow
//  y_valid_o   out  1                        y_o/y_rank_o/y_last_o valid
//  y_ready_i   in   1                        downstream accepts element
//  y_o         out  DATAWIDTH                current element
//  y_rank_o    out  RANKW                    rank of y_o within its vector (0 = largest)
//  y_last_o    out  1                        y_o is rank K-1 of its vector
//  busy_o      out  1                        at least one vector buffered
//  overflow_o  out  1                        sticky: a vector was dropped
// BEHAVIOUR
//  - Reset (async assert, sync release): all outputs 0; buffer empty; rank counter 0; pointers 0.
//  - Buffer: 2-entry FIFO of K-element vectors (only x_i[0..K-1] stored); wr_ptr, rd_ptr 1 bit; count 0..2.
//  - Capture: in_valid_i && (count<2 || pop this cycle) -> write x_i[0..K-1] at wr_ptr on that edge.
//  - Drop: in_valid_i && count==2 && no pop -> vector discarded, overflow_o set next cycle; FIFO untouched.
//  - Latency: vector captured at edge T into an empty buffer -> y_valid_o=1, y_o=x_i[0], y_rank_o=0 from T+1.
//  - y_valid_o = (count!=0); y_o = entry[rd_ptr][rank]; y_last_o = (rank==K-1).
//  - Handshake = y_valid_o && y_ready_i. On handshake: rank<K-1 -> rank+1; rank==K-1 -> rank=0, pop
//    (rd_ptr toggles, count-1). Simultaneous capture and pop keep count unchanged.
//  - While y_valid_o && !y_ready_i: y_o, y_rank_o, y_last_o held stable. y_ready_i with y_valid_o=0 ignored.
//  - FSM: IDLE (count==0) -> DRAIN on capture; DRAIN -> IDLE on last-pop with count==1 and no capture;
//    otherwise stays in DRAIN. busy_o = (state==DRAIN).
//  - K==1: every handshake is a pop; y_last_o constantly 1 while valid.
//  - overflow_o: set by drop, cleared by clr_ovf_i; set wins if both occur in the same cycle.
//  - Reset mid-drain: buffered vectors discarded, no element after reset release until a new capture.
// CONFIGURATION
//  TOPK_DROP_CNT_EN defined: adds port drop_cnt_o out 16, count of dropped vectors, reset 0,
//    increments on each drop, saturates at 16'hFFFF, cleared by clr_ovf_i (clear and drop same cycle -> 1).
//  Not defined: port absent; drops still indicated by overflow_o only.
// TESTING
//  1 Defaults, x_i[j]=100-j, one in_valid_i pulse at T, ready=1 -> y_o 100..93 on T+1..T+8, rank 0..7,
//    y_last_o only with 93, y_valid_o=0 and busy_o=0 at T+9.
//  2 Same vector, y_ready_i toggling 0/1 each cycle -> each of 100..93 held until accepted,
//    no skips or repeats, 16 cycles to drain.
//  3 Vectors A,B,C on three consecutive cycles, ready=0 -> C dropped, overflow_o=1 after C's edge,
//    ready=1 drains A's 8 then B's 8 elements; drop_cnt_o=1 with TOPK_DROP_CNT_EN.
//  4 Buffer full, in_valid_i on the same cycle as the rank-7 handshake -> vector captured,
//    overflow_o stays 0, next element is rank 0 of the following buffered vector.
//  5 rstn_i low while rank=3 -> outputs 0 immediately; after release with in_valid_i=0 -> y_valid_o stays 0.
//  6 clr_ovf_i on the same cycle as a drop -> overflow_o stays 1; clr_ovf_i alone next cycle -> 0.

Source files
------------

// File: rtl/topk_drain.sv
// Streams the top-K elements of each descending sorted vector over valid/ready. Build option: TOPK_DROP_CNT_EN adds drop_cnt_o.
// Latency: a vector captured into an empty buffer appears as rank 0 on the next cycle. Each handshake then advances one element.
// Backpressure: this block never stalls its input. It buffers two vectors and drops a third vector while the buffer is full.
module topk_drain #(
  parameter int DATAWIDTH  = 8,
  parameter int DATALENGTH = 32,
  parameter int K          = 8,
  localparam int RANKW     = (DATALENGTH > 1) ? $clog2(DATALENGTH) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 rstn_i,
  input  logic                                 in_valid_i,
  input  logic [DATALENGTH-1:0][DATAWIDTH-1:0] x_i,
  input  logic                                 clr_ovf_i,
  output logic                                 y_valid_o,
  input  logic                                 y_ready_i,
  output logic [DATAWIDTH-1:0]                 y_o,
  output logic [RANKW-1:0]                     y_rank_o,
  output logic                                 y_last_o,
  output logic                                 busy_o,
  output logic                                 overflow_o
`ifdef TOPK_DROP_CNT_EN
  ,
  output logic [15:0]                          drop_cnt_o
`endif
);

  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam logic [RANKW-1:0] LAST_RANK = RANKW'(K - 1);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  if (K < 1 || K > DATALENGTH) begin : g_bad_k
    $error("topk_drain: K must lie in 1..DATALENGTH");
  end

  logic [DATAWIDTH-1:0] mem [2][K];
  logic                 wr_ptr, rd_ptr;
  logic [1:0]           count;
  logic [RANKW-1:0]     rank;
  logic [0:0]           state;
  logic                 overflow;
  logic                 hs, pop, cap, drop, at_last, full;
  logic                 unused_x;

  // Elements beyond rank K-1 are never stored.
  assign unused_x = ^x_i;

  assign full    = (count == 2'd2);
  assign at_last = (rank == LAST_RANK);
  assign hs      = y_valid_o & y_ready_i;
  assign pop     = hs & at_last;
  assign cap     = in_valid_i & (~full | pop);
  assign drop    = in_valid_i & full & ~pop;

  assign y_valid_o  = (count != 2'd0);
  assign y_o        = y_valid_o ? mem[rd_ptr][rank[KW-1:0]] : '0;
  assign y_rank_o   = rank;
  assign y_last_o   = y_valid_o & at_last;
  assign busy_o     = (state == DRAIN);
  assign overflow_o = overflow;

  always_ff @(posedge clk_i) begin
    if (cap) begin
      for (int j = 0; j < K; j++) begin
        mem[wr_ptr][j] <= x_i[j];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      rank     <= '0;
      state    <= IDLE;
      overflow <= 1'b0;
    end else begin
      if (cap) wr_ptr <= ~wr_ptr;
      if (pop) rd_ptr <= ~rd_ptr;
      case ({cap, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (hs) rank <= at_last ? '0 : rank + RANKW'(1);
      case (state)
        IDLE:    if (cap) state <= DRAIN;
        DRAIN:   if (pop && count == 2'd1 && !cap) state <= IDLE;
        default: state <= IDLE;
      endcase
      // A drop in the same cycle as a clear leaves the flag set.
      if (drop)           overflow <= 1'b1;
      else if (clr_ovf_i) overflow <= 1'b0;
    end
  end

`ifdef TOPK_DROP_CNT_EN
  logic [15:0] drop_cnt;
  assign drop_cnt_o = drop_cnt;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      drop_cnt <= 16'd0;
    end else if (clr_ovf_i) begin
      drop_cnt <= drop ? 16'd1 : 16'd0;
    end else if (drop && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_topk_drain.sv
// Directed bench for topk_drain at default parameters (DATAWIDTH 8, DATALENGTH 32, K 8).
module tb_topk_drain;

  logic             clk = 1'b0;
  logic             rstn;
  logic             in_valid;
  logic [31:0][7:0] x;
  logic             clr_ovf;
  logic             y_valid;
  logic             y_ready;
  logic [7:0]       y;
  logic [4:0]       y_rank;
  logic             y_last;
  logic             busy;
  logic             overflow;
`ifdef TOPK_DROP_CNT_EN
  logic [15:0]      drop_cnt;
`endif

  always #5 clk = ~clk;

  topk_drain dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .in_valid_i (in_valid),
    .x_i        (x),
    .clr_ovf_i  (clr_ovf),
    .y_valid_o  (y_valid),
    .y_ready_i  (y_ready),
    .y_o        (y),
    .y_rank_o   (y_rank),
    .y_last_o   (y_last),
    .busy_o     (busy),
    .overflow_o (overflow)
`ifdef TOPK_DROP_CNT_EN
    ,
    .drop_cnt_o (drop_cnt)
`endif
  );

  // One row = inputs held across one rising edge, then the outputs expected after that edge.
  typedef struct {
    logic        iv, rdy, clr;
    logic [7:0]  base;
    logic        ev;
    logic [7:0]  ey;
    logic [4:0]  er;
    logic        eb, eo;
    logic [15:0] ed;
  } row_t;

  row_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic iv, input logic rdy, input logic clr, input logic [7:0] base,
                     input logic ev, input logic [7:0] ey, input logic [4:0] er,
                     input logic eb, input logic eo, input logic [15:0] ed);
    row_t r;
    r.iv = iv; r.rdy = rdy; r.clr = clr; r.base = base;
    r.ev = ev; r.ey = ey; r.er = er; r.eb = eb; r.eo = eo; r.ed = ed;
    tbl.push_back(r);
  endtask

  task automatic set_vec(input logic [7:0] base);
    for (int j = 0; j < 32; j++) x[j] = base - 8'(j);
  endtask

  task automatic check_row(input int idx, input row_t r);
    chk("y_valid", idx, 32'(y_valid), 32'(r.ev));
    if (r.ev) begin
      chk("y", idx, 32'(y), 32'(r.ey));
      chk("y_rank", idx, 32'(y_rank), 32'(r.er));
      chk("y_last", idx, 32'(y_last), 32'(r.er == 5'd7));
    end
    chk("busy", idx, 32'(busy), 32'(r.eb));
    chk("overflow", idx, 32'(overflow), 32'(r.eo));
`ifdef TOPK_DROP_CNT_EN
    chk("drop_cnt", idx, 32'(drop_cnt), 32'(r.ed));
`endif
  endtask

  initial begin
    rstn = 1'b0; in_valid = 1'b0; clr_ovf = 1'b0; y_ready = 1'b0;
    set_vec(8'd0);
    #1;
    chk("rst_y_valid", -1, 32'(y_valid), 32'd0);
    chk("rst_y", -1, 32'(y), 32'd0);
    chk("rst_busy", -1, 32'(busy), 32'd0);
    chk("rst_overflow", -1, 32'(overflow), 32'd0);
    chk("rst_y_last", -1, 32'(y_last), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Single vector, ready held high.
    add(1, 1, 0, 100, 1, 100, 0, 1, 0, 0);
    for (int i = 1; i < 8; i++) add(0, 1, 0, 0, 1, 8'(100 - i), 5'(i), 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Ready toggling: each element held through a low-ready cycle.
    add(1, 1, 0, 100, 1, 100, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      add(0, 0, 0, 0, 1, 8'(100 - i), 5'(i), 1, 0, 0);
      if (i < 7) add(0, 1, 0, 0, 1, 8'(99 - i), 5'(i + 1), 1, 0, 0);
      else       add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    end

    // A, B, C back to back with ready low: C dropped.
    add(1, 0, 0, 200, 1, 200, 0, 1, 0, 0);
    add(1, 0, 0, 150, 1, 200, 0, 1, 0, 0);
    add(1, 0, 0, 50,  1, 200, 0, 1, 1, 1);
    for (int i = 1; i < 8; i++) add(0, 1, 0, 0, 1, 8'(200 - i), 5'(i), 1, 1, 1);
    add(0, 1, 0, 0, 1, 150, 0, 1, 1, 1);
    for (int i = 1; i < 8; i++) add(0, 1, 0, 0, 1, 8'(150 - i), 5'(i), 1, 1, 1);
    add(0, 1, 0, 0, 0, 0, 0, 0, 1, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    // Full buffer, new vector on the rank-7 handshake: captured, not dropped.
    add(1, 0, 0, 120, 1, 120, 0, 1, 0, 0);
    add(1, 0, 0, 80,  1, 120, 0, 1, 0, 0);
    for (int i = 1; i < 8; i++) add(0, 1, 0, 0, 1, 8'(120 - i), 5'(i), 1, 0, 0);
    add(1, 1, 0, 60, 1, 80, 0, 1, 0, 0);
    for (int i = 1; i < 8; i++) add(0, 1, 0, 0, 1, 8'(80 - i), 5'(i), 1, 0, 0);
    add(0, 1, 0, 0, 1, 60, 0, 1, 0, 0);
    for (int i = 1; i < 8; i++) add(0, 1, 0, 0, 1, 8'(60 - i), 5'(i), 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Clear coincident with a drop: the set wins, and a later clear alone takes effect.
    add(1, 0, 0, 10, 1, 10, 0, 1, 0, 0);
    add(1, 0, 0, 30, 1, 10, 0, 1, 0, 0);
    add(1, 0, 1, 40, 1, 10, 0, 1, 1, 1);
    add(0, 0, 1, 0,  1, 10, 0, 1, 0, 0);
    for (int i = 1; i < 8; i++) add(0, 1, 0, 0, 1, 8'(10 - i), 5'(i), 1, 0, 0);
    add(0, 1, 0, 0, 1, 30, 0, 1, 0, 0);
    for (int i = 1; i < 8; i++) add(0, 1, 0, 0, 1, 8'(30 - i), 5'(i), 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      in_valid = tbl[i].iv;
      y_ready  = tbl[i].rdy;
      clr_ovf  = tbl[i].clr;
      set_vec(tbl[i].base);
      @(negedge clk);
      check_row(i, tbl[i]);
    end

    // Reset asserted mid-drain at rank 3.
    in_valid = 1'b1; y_ready = 1'b1; clr_ovf = 1'b0; set_vec(8'd100);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_rank", 1000, 32'(y_rank), 32'd3);
    chk("pre_rst_y", 1000, 32'(y), 32'd97);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_y_valid", 1001, 32'(y_valid), 32'd0);
    chk("mid_rst_y", 1001, 32'(y), 32'd0);
    chk("mid_rst_rank", 1001, 32'(y_rank), 32'd0);
    chk("mid_rst_last", 1001, 32'(y_last), 32'd0);
    chk("mid_rst_busy", 1001, 32'(busy), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_y_valid", 1002 + i, 32'(y_valid), 32'd0);
      chk("post_rst_busy", 1002 + i, 32'(busy), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
